// File: rtl/pwm_deadtime_gen.sv
// ---------------------------------------------------------------------------
// pwm_deadtime_gen
//   Turns the value of an upstream free-running N-bit up counter into a
//   complementary PWM pair (pwm_h / pwm_l) with programmable dead time, for a
//   half-bridge gate driver. Duty values arrive on a valid/ready handshake into
//   a shadow register and are only applied at counter wrap, so a period is
//   never cut short or stretched by a mid-period duty change.
//
// Ports
//   clk          system clock, all state on rising edge
//   reset        synchronous active-high reset
//   count_in     upstream counter value (N bits, +1 per cycle, wraps)
//   duty_in      requested duty in counts per period (N bits)
//   duty_valid   duty_in is valid
//   duty_ready   shadow register can accept a value (= !pending)
//   pwm_h        high-side drive, registered
//   pwm_l        low-side drive, registered, never high together with pwm_h
//   period_tick  one-cycle pulse aligned with the first raw bit of a period
//   active_duty  duty currently in use
//
// Dead-time FSM states
//   state | meaning
//   H_ON  | high side driven, raw == target == 1
//   L_ON  | low side driven,  raw == target == 0
//   DEAD  | both sides off, dead counter running toward target
// ---------------------------------------------------------------------------
module pwm_deadtime_gen #(
  parameter int N  = 4,
  parameter int DT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] count_in,
  input  logic [N-1:0] duty_in,
  input  logic         duty_valid,
  output logic         duty_ready,
  output logic         pwm_h,
  output logic         pwm_l,
  output logic         period_tick,
  output logic [N-1:0] active_duty
);

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [3:0]   DT_V    = 4'(DT);
  // The cycle that detects a raw change is already the first both-low cycle,
  // so the counter reloads with DT-1 to make the gap exactly DT cycles.
  localparam logic [3:0]   DT_RELOAD = (DT > 0) ? 4'(DT - 1) : 4'd0;

  typedef enum logic [1:0] {
    H_ON = 2'd0,
    L_ON = 2'd1,
    DEAD = 2'd2
  } state_t;

  logic [N-1:0] prev_count;
  logic [N-1:0] shadow;
  logic         pending;
  logic         raw;
  logic         wrap;
  logic         accept;
  logic [N-1:0] eff_duty;

  state_t       state, state_d;
  logic         target, target_d;
  logic [3:0]   dc, dc_d;
  logic         pwm_h_d, pwm_l_d;

  assign wrap       = (count_in == '0) && (prev_count == CNT_MAX);
  assign duty_ready = !pending;
  assign accept     = duty_valid && !pending;
  // The period that starts on this wrap already compares against the new duty.
  assign eff_duty   = (wrap && pending) ? shadow : active_duty;

  // Wrap detect, shadow handshake and compare
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_count  <= CNT_MAX;
      shadow      <= '0;
      pending     <= 1'b0;
      active_duty <= '0;
      raw         <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      prev_count  <= count_in;
      period_tick <= wrap;
      raw         <= (count_in < eff_duty);
      // accept needs pending==0 and apply needs pending==1: mutually exclusive
      if (accept) begin
        shadow  <= duty_in;
        pending <= 1'b1;
      end else if (wrap && pending) begin
        active_duty <= shadow;
        pending     <= 1'b0;
      end
    end
  end

  // FSM state register (outputs are registered alongside)
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= DEAD;
      target <= 1'b0;
      dc     <= DT_V;
      pwm_h  <= 1'b0;
      pwm_l  <= 1'b0;
    end else begin
      state  <= state_d;
      target <= target_d;
      dc     <= dc_d;
      pwm_h  <= pwm_h_d;
      pwm_l  <= pwm_l_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d  = state;
    target_d = target;
    dc_d     = dc;
    if (raw != target) begin
      target_d = raw;
      if (DT == 0) begin
        state_d = raw ? H_ON : L_ON;
      end else begin
        state_d = DEAD;
        dc_d    = DT_RELOAD;
      end
    end else if (state == DEAD) begin
      if (dc != 4'd0) begin
        dc_d = dc - 4'd1;
      end else begin
        state_d = target ? H_ON : L_ON;
      end
    end
  end

  // FSM outputs: decoded from the next state so they register with it
  always_comb begin
    pwm_h_d = (state_d == H_ON);
    pwm_l_d = (state_d == L_ON);
  end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// ---------------------------------------------------------------------------
// tb_pwm_deadtime_gen
//   Directed bench for pwm_deadtime_gen (N=4, DT=2). The bench plays the
//   upstream counter itself; outputs are sampled 1 time unit after each edge.
// ---------------------------------------------------------------------------
module tb_pwm_deadtime_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] count_in;
  logic [3:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm_h;
  logic       pwm_l;
  logic       period_tick;
  logic [3:0] active_duty;

  logic       cnt_en;
  int         n_cmp = 0;
  int         n_bad = 0;

  // measurement accumulators
  int m_h, m_l, m_both, m_ov, m_pt, m_first_h, m_rdy;

  pwm_deadtime_gen #(.N(4), .DT(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .count_in    (count_in),
    .duty_in     (duty_in),
    .duty_valid  (duty_valid),
    .duty_ready  (duty_ready),
    .pwm_h       (pwm_h),
    .pwm_l       (pwm_l),
    .period_tick (period_tick),
    .active_duty (active_duty)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (cnt_en) count_in = count_in + 4'd1;
  endtask

  task automatic run_to(input logic [3:0] c);
    for (int i = 0; i < 40 && count_in != c; i++) tick();
  endtask

  task automatic measure(input int n);
    m_h = 0; m_l = 0; m_both = 0; m_ov = 0; m_pt = 0; m_first_h = -1; m_rdy = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (pwm_h) m_h++;
      if (pwm_l) m_l++;
      if (!pwm_h && !pwm_l) m_both++;
      if (pwm_h && pwm_l) m_ov++;
      if (period_tick) m_pt++;
      if (duty_ready) m_rdy++;
      if (pwm_h && m_first_h < 0) m_first_h = i;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cnt_en = 1'b0; count_in = 4'd0; duty_in = 4'd0; duty_valid = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({pwm_h, pwm_l, period_tick, duty_ready} !== 4'b0001 || active_duty !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_state: h/l/tick/ready=%b%b%b%b active=%0d, want 0001 active=0",
               pwm_h, pwm_l, period_tick, duty_ready, active_duty);
    end
    reset = 1'b0; cnt_en = 1'b1;
    tick();
    n_cmp++;
    if (period_tick !== 1'b1 || pwm_l !== 1'b0) begin
      n_bad++;
      $display("FAIL first_wrap: tick=%b pwm_l=%b, want tick=1 pwm_l=0", period_tick, pwm_l);
    end
    tick();
    n_cmp++;
    if (pwm_l !== 1'b0) begin
      n_bad++;
      $display("FAIL pwm_l_edge2: got %b, want 0", pwm_l);
    end
    tick();
    n_cmp++;
    if (pwm_l !== 1'b1 || pwm_h !== 1'b0) begin
      n_bad++;
      $display("FAIL pwm_l_edge3: h=%b l=%b, want h=0 l=1", pwm_h, pwm_l);
    end
    measure(14);
    n_cmp++;
    if (m_l != 14 || m_h != 0 || m_pt != 1 || active_duty !== 4'd0) begin
      n_bad++;
      $display("FAIL idle_period: l=%0d h=%0d ticks=%0d active=%0d, want 14 0 1 0",
               m_l, m_h, m_pt, active_duty);
    end
  endtask

  task automatic test_duty_load();
    run_to(4'd8);
    duty_in = 4'd5; duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    run_to(4'd0);
    n_cmp++;
    if (duty_ready !== 1'b0 || active_duty !== 4'd0) begin
      n_bad++;
      $display("FAIL load5_pending: ready=%b active=%0d, want ready=0 active=0", duty_ready, active_duty);
    end
    tick();
    n_cmp++;
    if (active_duty !== 4'd5 || duty_ready !== 1'b1 || period_tick !== 1'b1) begin
      n_bad++;
      $display("FAIL load5_apply: active=%0d ready=%b tick=%b, want 5 1 1", active_duty, duty_ready, period_tick);
    end
    for (int p = 0; p < 2; p++) begin
      measure(16);
      n_cmp++;
      if (m_h != 3 || m_l != 9 || m_both != 4 || m_ov != 0 || m_pt != 1 || m_first_h != 3) begin
        n_bad++;
        $display("FAIL duty5_period%0d: h=%0d l=%0d both=%0d ov=%0d tick=%0d first_h=%0d, want 3 9 4 0 1 3",
                 p, m_h, m_l, m_both, m_ov, m_pt, m_first_h);
      end
    end
  endtask

  task automatic test_held_valid();
    // count 1 is next: load 7 so the shadow is pending, then hold 9 valid
    duty_in = 4'd7; duty_valid = 1'b1;
    tick();
    duty_in = 4'd9;
    m_rdy = 0;
    for (int i = 0; i < 40 && count_in != 4'd0; i++) begin
      tick();
      if (duty_ready) m_rdy++;
    end
    n_cmp++;
    if (m_rdy != 0 || active_duty !== 4'd5) begin
      n_bad++;
      $display("FAIL held_blocked: ready_cycles=%0d active=%0d, want 0 5", m_rdy, active_duty);
    end
    tick();
    n_cmp++;
    if (active_duty !== 4'd7 || duty_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL held_apply7: active=%0d ready=%b, want 7 1", active_duty, duty_ready);
    end
    tick();
    duty_valid = 1'b0;
    n_cmp++;
    if (duty_ready !== 1'b0 || active_duty !== 4'd7) begin
      n_bad++;
      $display("FAIL held_accept9: ready=%b active=%0d, want 0 7", duty_ready, active_duty);
    end
    run_to(4'd0);
    tick();
    n_cmp++;
    if (active_duty !== 4'd9) begin
      n_bad++;
      $display("FAIL held_apply9: active=%0d, want 9", active_duty);
    end
    measure(16);
    n_cmp++;
    if (m_h != 7 || m_l != 5 || m_both != 4 || m_ov != 0 || m_first_h != 3) begin
      n_bad++;
      $display("FAIL duty9_period: h=%0d l=%0d both=%0d ov=%0d first_h=%0d, want 7 5 4 0 3",
               m_h, m_l, m_both, m_ov, m_first_h);
    end
  endtask

  task automatic test_accept_on_wrap();
    run_to(4'd0);
    duty_in = 4'd12; duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    n_cmp++;
    if (active_duty !== 4'd9 || duty_ready !== 1'b0 || period_tick !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_accept: active=%0d ready=%b tick=%b, want 9 0 1", active_duty, duty_ready, period_tick);
    end
    run_to(4'd0);
    n_cmp++;
    if (active_duty !== 4'd9) begin
      n_bad++;
      $display("FAIL wrap_hold: active=%0d, want 9", active_duty);
    end
    tick();
    n_cmp++;
    if (active_duty !== 4'd12) begin
      n_bad++;
      $display("FAIL wrap_apply12: active=%0d, want 12", active_duty);
    end
    measure(16);
    n_cmp++;
    if (m_h != 10 || m_l != 2 || m_both != 4 || m_ov != 0) begin
      n_bad++;
      $display("FAIL duty12_period: h=%0d l=%0d both=%0d ov=%0d, want 10 2 4 0", m_h, m_l, m_both, m_ov);
    end
  endtask

  task automatic test_duty_max();
    duty_in = 4'd15; duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    run_to(4'd0);
    tick();
    n_cmp++;
    if (active_duty !== 4'd15) begin
      n_bad++;
      $display("FAIL max_apply: active=%0d, want 15", active_duty);
    end
    for (int p = 0; p < 2; p++) begin
      measure(16);
      n_cmp++;
      if (m_h != 13 || m_l != 0 || m_both != 3 || m_ov != 0 || m_first_h != 3) begin
        n_bad++;
        $display("FAIL duty15_period%0d: h=%0d l=%0d both=%0d ov=%0d first_h=%0d, want 13 0 3 0 3",
                 p, m_h, m_l, m_both, m_ov, m_first_h);
      end
    end
  endtask

  task automatic test_reset_mid();
    duty_in = 4'd5; duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    run_to(4'd0);
    tick();
    duty_in = 4'd10; duty_valid = 1'b1;
    tick();
    duty_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (pwm_h !== 1'b1 || duty_ready !== 1'b0 || active_duty !== 4'd5) begin
      n_bad++;
      $display("FAIL pre_reset: h=%b ready=%b active=%0d, want 1 0 5", pwm_h, duty_ready, active_duty);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if ({pwm_h, pwm_l, period_tick, duty_ready} !== 4'b0001 || active_duty !== 4'd0) begin
      n_bad++;
      $display("FAIL mid_reset: h/l/tick/ready=%b%b%b%b active=%0d, want 0001 0",
               pwm_h, pwm_l, period_tick, duty_ready, active_duty);
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (pwm_l !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_l2: got %b, want 0", pwm_l);
    end
    tick();
    n_cmp++;
    if (pwm_l !== 1'b1) begin
      n_bad++;
      $display("FAIL post_reset_l3: got %b, want 1", pwm_l);
    end
    run_to(4'd0);
    tick();
    n_cmp++;
    if (period_tick !== 1'b1 || active_duty !== 4'd0 || duty_ready !== 1'b1 || pwm_h !== 1'b0) begin
      n_bad++;
      $display("FAIL pending_discard: tick=%b active=%0d ready=%b h=%b, want 1 0 1 0",
               period_tick, active_duty, duty_ready, pwm_h);
    end
  endtask

  task automatic test_jump();
    run_to(4'd7);
    count_in = 4'd0;
    tick();
    n_cmp++;
    if (period_tick !== 1'b0) begin
      n_bad++;
      $display("FAIL jump_not_wrap: tick=%b, want 0", period_tick);
    end
    run_to(4'd0);
    tick();
    n_cmp++;
    if (period_tick !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_after_jump: tick=%b, want 1", period_tick);
    end
  endtask

  initial begin
    test_reset();
    test_duty_load();
    test_held_valid();
    test_accept_on_wrap();
    test_duty_max();
    test_reset_mid();
    test_jump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
